// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)) for 32-bit unsigned operands.
// Restoring digit-by-digit recurrence, ITER_PER_STAGE root bits per register stage.
module isqrt_pipe #(
    parameter int ITER_PER_STAGE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);

    localparam int LATENCY = 16 / ITER_PER_STAGE;

    if (!(ITER_PER_STAGE inside {1, 2, 4, 8, 16})) begin : g_bad_param
        $error("isqrt_pipe: ITER_PER_STAGE must be 1, 2, 4, 8 or 16");
    end

    // rem never exceeds 2*root, so 17 bits hold it for a 16-bit root.
    typedef struct packed {
        logic [16:0] rem;
        logic [15:0] root;
        logic [31:0] op;
    } stage_t;

    stage_t             st_d [LATENCY];
    stage_t             st_q [LATENCY];
    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] vld_q;
    stage_t             seed;

    function automatic stage_t resolve(input stage_t s_in);
        stage_t      s;
        logic [18:0] acc;
        logic [18:0] sub;
        s = s_in;
        for (int i = 0; i < ITER_PER_STAGE; i++) begin
            acc = {s.rem, s.op[31:30]};
            sub = {1'b0, s.root, 2'b01};
            if (acc >= sub) begin
                s.rem  = 17'(acc - sub);
                s.root = {s.root[14:0], 1'b1};
            end else begin
                s.rem  = acc[16:0];
                s.root = {s.root[14:0], 1'b0};
            end
            s.op = {s.op[29:0], 2'b00};
        end
        return s;
    endfunction

    always_comb begin
        seed      = '0;
        seed.op   = x;
        st_d[0]   = resolve(seed);
        vld_d[0]  = x_vld;
        for (int k = 1; k < LATENCY; k++) begin
            st_d[k]  = resolve(st_q[k-1]);
            vld_d[k] = vld_q[k-1];
        end
    end

    // Only the valid bits are reset; the datapath free-runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LATENCY; k++) begin
            st_q[k] <= st_d[k];
        end
    end

    assign y_vld = vld_q[LATENCY-1];
    assign y     = st_q[LATENCY-1].root;

endmodule

// File: tb/tb_isqrt_pipe.sv
// Random and directed checks of isqrt_pipe at ITER_PER_STAGE 1, 4 and 16 against
// an arithmetic floor(sqrt) model with edge-indexed issue history.
module tb_isqrt_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x = '0;
    logic        v_a, v_b, v_c;
    logic [15:0] y_a, y_b, y_c;

    isqrt_pipe #(.ITER_PER_STAGE(1))  dut_a (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(v_a), .y(y_a));
    isqrt_pipe #(.ITER_PER_STAGE(4))  dut_b (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(v_b), .y(y_b));
    isqrt_pipe #(.ITER_PER_STAGE(16)) dut_c (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(v_c), .y(y_c));

    always #5 clk = ~clk;

    localparam int HMAX = 32768;
    bit          acc_h [HMAX];
    bit          rst_h [HMAX];
    logic [31:0] x_h   [HMAX];
    int          lit_h [HMAX];
    int          lat   [3] = '{16, 4, 1};
    int          n_out [3] = '{0, 0, 0};
    int          n_exp [3] = '{0, 0, 0};
    int          ecount = 0;
    int          cur_lit = -1;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [15:0] isq(input logic [31:0] v);
        longint r;
        longint vv;
        vv = longint'(v);
        r  = longint'($sqrt(real'(vv)));
        while (r * r > vv) r--;
        while ((r + 1) * (r + 1) <= vv) r++;
        return r[15:0];
    endfunction

    initial forever begin
        @(posedge clk);
        ecount++;
    end

    // Output after edge e comes from the operand accepted at edge e-L+1,
    // provided no reset was sampled on any later edge up to e.
    initial forever begin
        int          e, t;
        bit          ev, dv;
        logic [15:0] dy, ex;
        @(negedge clk);
        e = ecount;
        if (e >= 1) begin
            for (int d = 0; d < 3; d++) begin
                t  = e - lat[d] + 1;
                ev = 1'b0;
                if (t >= 1 && acc_h[t]) begin
                    ev = 1'b1;
                    for (int j = t + 1; j <= e; j++) if (rst_h[j]) ev = 1'b0;
                end
                case (d)
                    0: begin dv = v_a; dy = y_a; end
                    1: begin dv = v_b; dy = y_b; end
                    default: begin dv = v_c; dy = y_c; end
                endcase
                tests++;
                if (dv !== ev) begin
                    fails++;
                    $display("FAIL y_vld L=%0d edge=%0d: got %b want %b", lat[d], e, dv, ev);
                end
                if (dv === 1'b1) n_out[d]++;
                if (ev) begin
                    n_exp[d]++;
                    ex = isq(x_h[t]);
                    tests++;
                    if (dy !== ex) begin
                        fails++;
                        $display("FAIL y L=%0d x=%h: got %h want %h", lat[d], x_h[t], dy, ex);
                    end
                    if (lit_h[t] >= 0) begin
                        tests++;
                        if (dy !== lit_h[t][15:0]) begin
                            fails++;
                            $display("FAIL y_literal L=%0d x=%h: got %h want %h", lat[d], x_h[t], dy, lit_h[t][15:0]);
                        end
                    end
                end
            end
        end
        if (e + 1 < HMAX) begin
            rst_h[e+1] = rst;
            acc_h[e+1] = x_vld && !rst;
            x_h[e+1]   = x;
            lit_h[e+1] = cur_lit;
        end
    end

    task automatic step(input bit v, input logic [31:0] val, input int lit);
        @(posedge clk);
        #1;
        x_vld   = v;
        x       = val;
        cur_lit = v ? lit : -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, -1);
    endtask

    int          bx   [10] = '{0, 1, 2, 3, 4, 15, 16, 17, 99, 100};
    int          by   [10] = '{0, 1, 1, 1, 2, 3, 4, 4, 9, 10};
    logic [31:0] ext  [4]  = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000, 32'h4000_0000};
    int          exty [4]  = '{'hFFFF, 'hFFFF, 'hFFFE, 'h8000};
    bit          bv   [7]  = '{1, 0, 1, 1, 0, 0, 1};
    int          bxx  [7]  = '{25, 0, 36, 49, 0, 0, 64};
    int          byy  [7]  = '{5, -1, 6, 7, -1, -1, 8};

    initial begin
        logic [31:0] r, rv;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        step(1'b1, 32'd144, 12);
        idle(20);
        for (int i = 0; i < 10; i++) step(1'b1, bx[i], by[i]);
        idle(20);
        for (int i = 0; i < 4; i++) step(1'b1, ext[i], exty[i]);
        step(1'b1, 32'd3, 1);
        idle(20);
        for (int i = 0; i < 7; i++) step(bv[i], bxx[i], byy[i]);
        idle(20);

        // Reset lands while the long pipeline still holds these operands.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, -1);
        idle(7);
        @(posedge clk);
        #1;
        rst = 1'b1; x_vld = 1'b1; x = 32'd81; cur_lit = -1;
        @(posedge clk);
        #1;
        rst = 1'b0; x_vld = 1'b0;
        step(1'b1, 32'd10000, 100);
        idle(20);

        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(3))
                0: rv = $urandom_range(1000);
                1: begin
                    r  = $urandom_range(65535);
                    rv = r * r + 32'($urandom_range(2)) - 32'd1;
                end
                default: rv = $urandom;
            endcase
            step($urandom_range(99) < 70, rv, -1);
        end
        idle(24);

        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (n_out[d] != n_exp[d] || n_exp[d] < 5000) begin
                fails++;
                $display("FAIL result_count L=%0d: got %0d results want %0d", lat[d], n_out[d], n_exp[d]);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
